branch_unit: RTL and testbench
==============================

# branch_unit

Branch unit for the RV32 integer core: compares two 32-bit register operands under a 3-bit branch condition and reports whether the branch is taken. Sits in the execute stage beside the ALU. The combinational decision feeds same-cycle redirect logic. A registered copy with a valid flag feeds the commit/redirect pipeline.

## Interface
- Parameters: XLEN, default 32, operand width. Only 32 is required to be supported.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_a  input  XLEN  first operand (rs1).
- i_b  input  XLEN  second operand (rs2).
- i_cmp_op  input  3  branch condition code (encodings under Structure).
- i_valid  input  1  a branch instruction is present this cycle.
- o_taken  output  1  combinational decision for the current i_a/i_b/i_cmp_op.
- o_taken_q  output  1  o_taken registered at the clock edge when i_valid=1.
- o_valid_q  output  1  i_valid registered; marks o_taken_q as meaningful.

## Operation
- BEQ: taken when a == b.
- BNE: taken when a != b.
- BLT: taken when signed(a) < signed(b), two's complement.
- BGE: taken when signed(a) >= signed(b).
- BLTU: taken when unsigned(a) < unsigned(b).
- BGEU: taken when unsigned(a) >= unsigned(b).
- Reserved codes 3'b010 and 3'b011 give o_taken = 0. This is not an error and there is no trap output.
- o_taken is purely combinational from i_a, i_b and i_cmp_op. It does not depend on i_valid, i_clk or i_rst. It holds no state and is never X when the inputs are known.
- The signed compare must handle the sign-bit cases correctly. Example: a = 0xFFFFFFFC (-4), b = 10 gives BLT taken and BLTU not taken.
- Equal operands: BEQ, BGE and BGEU are taken; BNE, BLT and BLTU are not.

## Timing
- o_taken: zero latency. It settles within the same cycle as its inputs, and the path must close timing in one cycle at the core clock.
- On each rising edge:
  - o_valid_q <= i_valid.
  - o_taken_q <= o_taken when i_valid = 1.
  - o_taken_q <= 0 when i_valid = 0.
- Registered outputs have a latency of 1 cycle.
- Reset value of every registered output is 0. While i_rst is high, o_taken_q = 0 and o_valid_q = 0 immediately, with no clock edge needed.
- Reset asserted mid-operation discards any in-flight registered result. o_taken keeps tracking its inputs during reset.
- Back-to-back valid branches are accepted every cycle with no stalls. There is no backpressure.

## Structure
- Shared header bu.mac.vh defines the condition codes (RISC-V funct3):
  - BU_BEQ = 3'b000
  - BU_BNE = 3'b001
  - BU_BLT = 3'b100
  - BU_BGE = 3'b101
  - BU_BLTU = 3'b110
  - BU_BGEU = 3'b111
- The decode stage and the testbench include the same header.
- One natural sub-module, bu_cmp, is purely combinational. It produces eq, lt_s and lt_u from a single shared subtraction/compare. The top selects among them and inverts for the NE/GE/GEU codes.
- The top holds the op mux and the two output flops.

## Test plan
- a=-4 (0xFFFFFFFC), b=10, sweep the ops, checking o_taken 1 time unit after each change:
  - BEQ -> 0
  - BNE -> 1
  - BLT -> 1
  - BGE -> 0
  - BLTU -> 0
  - BGEU -> 1
- a=b=0x80000000 -> BEQ/BGE/BGEU = 1; BNE/BLT/BLTU = 0.
- a=0x7FFFFFFF, b=0x80000000:
  - BLT = 0, BGE = 1
  - BLTU = 1, BGEU = 0
- Reserved ops 3'b010 and 3'b011 with a=1, b=2 -> o_taken = 0.
- Pipeline sequence with i_valid=1: cycle 0 BEQ 5==5, cycle 1 BNE 5==5, then i_valid=0.
  - Expected o_taken_q/o_valid_q: 1/1 after the first edge, 0/1 after the second, 0/0 after the third.
- Assert i_rst asynchronously between edges while o_taken_q=1 -> o_taken_q and o_valid_q drop to 0 immediately. After i_rst deasserts, the first valid op registers correctly on the next edge.

Source files
------------

// File: rtl/branch_unit_pkg.sv
// Shared branch condition codes (RISC-V funct3) for the branch unit, decode and bench.
package branch_unit_pkg;

    localparam logic [2:0] BU_BEQ  = 3'b000;
    localparam logic [2:0] BU_BNE  = 3'b001;
    localparam logic [2:0] BU_BLT  = 3'b100;
    localparam logic [2:0] BU_BGE  = 3'b101;
    localparam logic [2:0] BU_BLTU = 3'b110;
    localparam logic [2:0] BU_BGEU = 3'b111;

endpackage

// File: rtl/bu_cmp.sv
// Combinational comparator: eq, signed-lt and unsigned-lt derived from one subtraction.
module bu_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_eq,
    output logic            o_lt_s,
    output logic            o_lt_u
);

    logic [XLEN:0] diff;

    // The extra top bit is the borrow: set exactly when a < b unsigned.
    assign diff   = {1'b0, i_a} - {1'b0, i_b};
    assign o_lt_u = diff[XLEN];
    assign o_eq   = (diff[XLEN-1:0] == '0);
    // Differing signs: the negative operand is smaller; same signs: unsigned order holds.
    assign o_lt_s = (i_a[XLEN-1] ^ i_b[XLEN-1]) ? i_a[XLEN-1] : o_lt_u;

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch unit: combinational taken decision plus a registered copy with valid.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [2:0]      i_cmp_op,
    input  logic            i_valid,
    output logic            o_taken,
    output logic            o_taken_q,
    output logic            o_valid_q
);

    logic eq, lt_s, lt_u;
    logic taken_d, taken_q;
    logic valid_d, valid_q;

    bu_cmp #(.XLEN(XLEN)) u_cmp (
        .i_a    (i_a),
        .i_b    (i_b),
        .o_eq   (eq),
        .o_lt_s (lt_s),
        .o_lt_u (lt_u)
    );

    always_comb begin
        o_taken = 1'b0;
        unique case (i_cmp_op)
            BU_BEQ:  o_taken = eq;
            BU_BNE:  o_taken = ~eq;
            BU_BLT:  o_taken = lt_s;
            BU_BGE:  o_taken = ~lt_s;
            BU_BLTU: o_taken = lt_u;
            BU_BGEU: o_taken = ~lt_u;
            default: o_taken = 1'b0;
        endcase
    end

    always_comb begin
        valid_d = i_valid;
        taken_d = i_valid & o_taken;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            taken_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            taken_q <= taken_d;
            valid_q <= valid_d;
        end
    end

    assign o_taken_q = taken_q;
    assign o_valid_q = valid_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: stimulus pushes expectations, a monitor pops and compares.
module tb_branch_unit;
    import branch_unit_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_a, i_b;
    logic [2:0]  i_cmp_op;
    logic        i_valid;
    logic        o_taken, o_taken_q, o_valid_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        bit    chk_comb;
        bit    chk_reg;
        logic  taken;
        logic  taken_q;
        logic  valid_q;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;

    branch_unit #(.XLEN(32)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_cmp_op  (i_cmp_op),
        .i_valid   (i_valid),
        .o_taken   (o_taken),
        .o_taken_q (o_taken_q),
        .o_valid_q (o_valid_q)
    );

    always #5 i_clk = ~i_clk;

    // Monitor: drains every pending expectation against the DUT outputs.
    initial begin
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_comb) begin
                    checks++;
                    if (o_taken !== e.taken) begin
                        errors++;
                        $display("FAIL %s o_taken got %b want %b", e.name, o_taken, e.taken);
                    end
                end
                if (e.chk_reg) begin
                    checks++;
                    if (o_taken_q !== e.taken_q || o_valid_q !== e.valid_q) begin
                        errors++;
                        $display("FAIL %s taken_q/valid_q got %b/%b want %b/%b",
                                 e.name, o_taken_q, o_valid_q, e.taken_q, e.valid_q);
                    end
                end
            end
        end
    end

    task automatic push_comb(input string name, input logic t);
        exp_t e;
        e = '{name: name, chk_comb: 1'b1, chk_reg: 1'b0, taken: t, taken_q: 1'b0, valid_q: 1'b0};
        exp_q.push_back(e);
        ->chk_ev;
    endtask

    task automatic push_reg(input string name, input logic tq, input logic vq);
        exp_t e;
        e = '{name: name, chk_comb: 1'b0, chk_reg: 1'b1, taken: 1'b0, taken_q: tq, valid_q: vq};
        exp_q.push_back(e);
        ->chk_ev;
    endtask

    task automatic comb(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic t);
        i_a = a; i_b = b; i_cmp_op = op;
        #1;
        push_comb(name, t);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1; i_valid = 1'b0;
        i_a = 32'd0; i_b = 32'd0; i_cmp_op = BU_BEQ;
        #2;
        push_reg("reset_state", 1'b0, 1'b0);
        #1;
        comb("comb_during_reset", 32'd7, 32'd7, BU_BEQ, 1'b1);
        @(negedge i_clk);
        i_rst = 1'b0;

        // a=-4, b=10 op sweep
        comb("m4_10_beq",  32'hFFFFFFFC, 32'd10, BU_BEQ,  1'b0);
        comb("m4_10_bne",  32'hFFFFFFFC, 32'd10, BU_BNE,  1'b1);
        comb("m4_10_blt",  32'hFFFFFFFC, 32'd10, BU_BLT,  1'b1);
        comb("m4_10_bge",  32'hFFFFFFFC, 32'd10, BU_BGE,  1'b0);
        comb("m4_10_bltu", 32'hFFFFFFFC, 32'd10, BU_BLTU, 1'b0);
        comb("m4_10_bgeu", 32'hFFFFFFFC, 32'd10, BU_BGEU, 1'b1);
        // equal operands at the most negative value
        comb("eq_beq",  32'h80000000, 32'h80000000, BU_BEQ,  1'b1);
        comb("eq_bne",  32'h80000000, 32'h80000000, BU_BNE,  1'b0);
        comb("eq_blt",  32'h80000000, 32'h80000000, BU_BLT,  1'b0);
        comb("eq_bge",  32'h80000000, 32'h80000000, BU_BGE,  1'b1);
        comb("eq_bltu", 32'h80000000, 32'h80000000, BU_BLTU, 1'b0);
        comb("eq_bgeu", 32'h80000000, 32'h80000000, BU_BGEU, 1'b1);
        // max positive vs min negative
        comb("mx_blt",  32'h7FFFFFFF, 32'h80000000, BU_BLT,  1'b0);
        comb("mx_bge",  32'h7FFFFFFF, 32'h80000000, BU_BGE,  1'b1);
        comb("mx_bltu", 32'h7FFFFFFF, 32'h80000000, BU_BLTU, 1'b1);
        comb("mx_bgeu", 32'h7FFFFFFF, 32'h80000000, BU_BGEU, 1'b0);
        // reserved codes
        comb("rsv_010", 32'd1, 32'd2, 3'b010, 1'b0);
        comb("rsv_011", 32'd1, 32'd2, 3'b011, 1'b0);
        comb("ltu_1_2", 32'd1, 32'd2, BU_BLTU, 1'b1);

        // pipeline sequence
        @(negedge i_clk);
        i_valid = 1'b1; i_a = 32'd5; i_b = 32'd5; i_cmp_op = BU_BEQ;
        @(posedge i_clk); #1;
        push_reg("pipe_c0_beq", 1'b1, 1'b1);
        @(negedge i_clk);
        i_cmp_op = BU_BNE;
        @(posedge i_clk); #1;
        push_reg("pipe_c1_bne", 1'b0, 1'b1);
        @(negedge i_clk);
        i_valid = 1'b0; i_cmp_op = BU_BEQ;
        @(posedge i_clk); #1;
        push_reg("pipe_c2_idle", 1'b0, 1'b0);

        // asynchronous reset while a taken result is held
        @(negedge i_clk);
        i_valid = 1'b1; i_a = 32'd5; i_b = 32'd5; i_cmp_op = BU_BEQ;
        @(posedge i_clk); #1;
        push_reg("pre_rst_taken", 1'b1, 1'b1);
        #2;
        i_rst = 1'b1;
        #1;
        push_reg("async_rst_clear", 1'b0, 1'b0);
        push_comb("comb_tracks_in_rst", 1'b1);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_a = 32'hFFFFFFFC; i_b = 32'd10; i_cmp_op = BU_BLT;
        @(posedge i_clk); #1;
        push_reg("post_rst_blt", 1'b1, 1'b1);
        @(negedge i_clk);
        i_valid = 1'b0; i_a = 32'd1; i_b = 32'd2; i_cmp_op = BU_BLTU;
        @(posedge i_clk); #1;
        push_reg("post_rst_idle", 1'b0, 1'b0);

        #2;
        ->chk_ev;
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
